// File: rtl/sqrt_pkg.sv
// Shared definitions for the restoring square-root sequencer: state codes,
// default radicand width and counter sizing.
package sqrt_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_ROOT_W = DEFAULT_WIDTH / 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_CALC = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // A one-iteration configuration still needs a 1-bit counter to be legal.
    function automatic int cnt_width(input int root_w);
        return (root_w > 1) ? $clog2(root_w) : 1;
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_ROOT_W);

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root iteration: brings in two radicand bits, performs
// the trial subtraction and produces the next partial root and remainder.
module sqrt_step
    import sqrt_pkg::*;
#(
    parameter int ROOT_W = DEFAULT_ROOT_W
) (
    input  logic [ROOT_W:0]   rem,
    input  logic [ROOT_W-1:0] root,
    input  logic [1:0]        a_msb2,
    output logic [ROOT_W:0]   rem_next,
    output logic [ROOT_W-1:0] root_next
);

    localparam int EXT_W = ROOT_W + 3;

    logic [EXT_W-1:0] p;
    logic [EXT_W-1:0] t;
    logic [EXT_W-1:0] diff;
    logic             ge;

    // The rem <= 2*root invariant keeps the kept remainder within ROOT_W+1 bits.
    always_comb begin
        p         = {rem, a_msb2};
        t         = {1'b0, root, 2'b01};
        diff      = p - t;
        ge        = (p >= t);
        rem_next  = (ROOT_W + 1)'(ge ? diff : p);
        root_next = (root << 1) | ROOT_W'(ge);
    end

endmodule

// File: rtl/sqrt_rem_ctrl.sv
// Sequencer for the digit-by-digit square root: drives the A/R shifter strobes,
// iterates sqrt_step once per CALC cycle and holds the final root/remainder.
module sqrt_rem_ctrl
    import sqrt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_ld,
    input  logic                 start,
    input  logic [1:0]           a_msb2,
    output logic                 lda2,
    output logic                 shift,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH/2-1:0]   root,
    output logic [WIDTH/2:0]     rem
);

    localparam int ROOT_W = WIDTH / 2;
    localparam int CNT_W  = cnt_width(ROOT_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROOT_W - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ROOT_W-1:0] root_q, root_d;
    logic [ROOT_W:0]   rem_q, rem_d;
    logic              lda2_q, lda2_d;
    logic              shift_q, shift_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [ROOT_W-1:0] root_step;
    logic [ROOT_W:0]   rem_step;

    sqrt_step #(
        .ROOT_W (ROOT_W)
    ) u_step (
        .rem       (rem_q),
        .root      (root_q),
        .a_msb2    (a_msb2),
        .rem_next  (rem_step),
        .root_next (root_step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        root_d  = root_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                root_d  = '0;
                rem_d   = '0;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                root_d = root_step;
                rem_d  = rem_step;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are registered straight from the next state so they come out of
    // flops, never from a decode of the state bits.
    always_comb begin
        lda2_d  = (state_d == ST_LOAD);
        shift_d = (state_d == ST_CALC);
        busy_d  = (state_d == ST_LOAD) || (state_d == ST_CALC);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst_ld) begin
        if (rst_ld) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            lda2_q  <= 1'b0;
            shift_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            lda2_q  <= lda2_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign lda2  = lda2_q;
    assign shift = shift_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign root  = root_q;
    assign rem   = rem_q;

endmodule

// File: tb/tb_sqrt_rem_ctrl.sv
// Scoreboard bench for sqrt_rem_ctrl: models the A shifter, predicts results
// from integer arithmetic and checks them whenever done pulses.
module tb_sqrt_rem_ctrl;

    localparam int WIDTH  = 16;
    localparam int ROOT_W = WIDTH / 2;

    logic              clk = 1'b0;
    logic              rst_ld;
    logic              start;
    logic [1:0]        a_msb2;
    logic              lda2, shift, busy, done;
    logic [ROOT_W-1:0] root;
    logic [ROOT_W:0]   rem;

    logic [WIDTH-1:0]  radicand;
    logic [WIDTH-1:0]  a_reg;

    int exp_root_q[$];
    int exp_rem_q[$];
    int checks = 0;
    int errors = 0;

    sqrt_rem_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_ld (rst_ld),
        .start  (start),
        .a_msb2 (a_msb2),
        .lda2   (lda2),
        .shift  (shift),
        .busy   (busy),
        .done   (done),
        .root   (root),
        .rem    (rem)
    );

    always #5 clk = ~clk;

    // Upstream A register: captures on lda2, shifts left by two on shift.
    always @(posedge clk) begin
        if (lda2)       a_reg <= radicand;
        else if (shift) a_reg <= a_reg << 2;
    end
    assign a_msb2 = a_reg[WIDTH-1 -: 2];

    function automatic void ref_sqrt(input int x, output int r, output int m);
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        m = x - r * r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (!rst_ld && done) begin
            if (exp_root_q.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                checkOutput("root", int'(root), exp_root_q.pop_front());
                checkOutput("rem", int'(rem), exp_rem_q.pop_front());
            end
        end
    end

    task automatic push_expected(input int x);
        int r, m;
        ref_sqrt(x, r, m);
        exp_root_q.push_back(r);
        exp_rem_q.push_back(m);
    endtask

    task automatic applyStimulus(input int x);
        int n;
        @(negedge clk);
        radicand = WIDTH'(x);
        start    = 1'b1;
        push_expected(x);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_seen", int'(done), 1);
    endtask

    initial begin
        int done_k[$];
        int sched[$];
        int idx;

        rst_ld   = 1'b1;
        start    = 1'b0;
        radicand = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_lda2", int'(lda2), 0);
        checkOutput("reset_shift", int'(shift), 0);
        checkOutput("reset_root", int'(root), 0);
        checkOutput("reset_rem", int'(rem), 0);
        rst_ld = 1'b0;
        @(negedge clk);

        // Radicand 144 with cycle-accurate strobe timing.
        radicand = 16'd144;
        start    = 1'b1;
        push_expected(144);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            checkOutput($sformatf("lda2_c%0d", k), int'(lda2), (k == 1) ? 1 : 0);
            checkOutput($sformatf("shift_c%0d", k), int'(shift), (k >= 2 && k <= 9) ? 1 : 0);
            checkOutput($sformatf("busy_c%0d", k), int'(busy), (k >= 1 && k <= 9) ? 1 : 0);
            checkOutput($sformatf("done_c%0d", k), int'(done), (k == 10) ? 1 : 0);
        end

        applyStimulus(65535);
        applyStimulus(0);
        applyStimulus(2);

        // Radicand 1000 with start re-pulsed mid-operation and during DONE.
        @(negedge clk);
        radicand = 16'd1000;
        start    = 1'b1;
        push_expected(1000);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = (k == 3 || k == 10) ? 1'b1 : 1'b0;
            if (k <= 9)  checkOutput($sformatf("busy1000_c%0d", k), int'(busy), 1);
            if (k == 10) checkOutput("done1000", int'(done), 1);
            if (k >= 12) checkOutput($sformatf("idle1000_c%0d", k), int'(busy), 0);
        end

        // Radicand 50000 aborted by reset in cycle 5, then rerun.
        @(negedge clk);
        radicand = 16'd50000;
        start    = 1'b1;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        checkOutput("pre_reset_busy", int'(busy), 1);
        rst_ld = 1'b1;
        #1;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_shift", int'(shift), 0);
        checkOutput("abort_root", int'(root), 0);
        checkOutput("abort_rem", int'(rem), 0);
        @(negedge clk);
        rst_ld = 1'b0;
        applyStimulus(50000);

        // start held high across three operations.
        @(negedge clk);
        sched = '{4, 9, 17};
        idx = 0;
        radicand = 16'd4;
        for (int i = 0; i < 3; i++) push_expected(sched[i]);
        start = 1'b1;
        for (int k = 1; k <= 40 && done_k.size() < 3; k++) begin
            @(negedge clk);
            if (done) begin
                done_k.push_back(k);
                idx++;
                if (idx < 3) radicand = WIDTH'(sched[idx]);
                else start = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput("b2b_count", done_k.size(), 3);
        if (done_k.size() == 3) begin
            checkOutput("b2b_first", done_k[0], 10);
            checkOutput("b2b_gap1", done_k[1] - done_k[0], 11);
            checkOutput("b2b_gap2", done_k[2] - done_k[1], 11);
        end
        @(negedge clk);
        checkOutput("b2b_done_width", int'(done), 0);

        // Randomised radicands against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            applyStimulus(int'($urandom_range(0, 65535)));
        end

        repeat (3) @(negedge clk);
        checkOutput("queue_empty", exp_root_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
